col_feeder: RTL

- Transmit-side counterpart of the pixel unit's col_data input.
- Accepts a raster pixel stream (one PB-bit pixel per accepted beat, row-major) and buffers NM-1 previous image rows in line memories.
- For each accepted pixel, emits the vertical column of NM pixels at that x position, which feeds the pixel unit's column processor.
- Suppresses output while the line memories prime, and tracks x/y position, line and frame boundaries.

---
 rtl/pxl_pkg.sv | 16 +
 rtl/line_mem.sv | 25 ++
 rtl/col_feeder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pxl_pkg.sv
// Shared pixel-path types and default widths for the feeder and the pixel unit.
package pxl_pkg;

   localparam int unsigned DefPb = 8;
   localparam int unsigned DefXb = 10;
   localparam int unsigned DefYb = 10;
   localparam int unsigned DefNm = 4;

   typedef logic [DefPb-1:0] pixel_t;

   typedef enum logic {
      PRIME,
      STREAM
   } feeder_state_t;

endpackage

// File: rtl/line_mem.sv
// One image-row line buffer: register array, combinational read, write-enabled store.
module line_mem #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 640,
   parameter int unsigned AddrW = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AddrW-1:0] addr,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata
);

   logic [Width-1:0] mem [Depth];

   // No reset: contents are masked by the feeder's priming phase.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/col_feeder.sv
// Raster-to-column feeder: buffers NM-1 rows and emits the NM-pixel column at each accepted x.
module col_feeder
   import pxl_pkg::*;
#(
   parameter int unsigned XB    = DefXb,
   parameter int unsigned YB    = DefYb,
   parameter int unsigned PB    = DefPb,
   parameter int unsigned NM    = DefNm,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [PB-1:0] pix_in,
   input  logic          pix_sof,
   input  logic          pix_valid,
   output logic          pix_ready,
   output logic [PB-1:0] col_data [NM-1:0],
   output logic          col_valid,
   input  logic          col_ready,
   output logic          col_sol,
   output logic          col_eof,
   output logic [XB-1:0] col_x
);

   localparam int unsigned   AW         = $clog2(IMG_W);
   localparam logic [XB-1:0] XLast      = XB'(IMG_W - 1);
   localparam logic [YB-1:0] YLast      = YB'(IMG_H - 1);
   localparam logic [YB-1:0] YPrimeLast = YB'(NM - 2);
   localparam logic [YB-1:0] YFirstOut  = YB'(NM - 1);

   logic          acc, sof_acc, last_pix;
   logic [XB-1:0] x_q, x_d, eff_x;
   logic [YB-1:0] y_q, y_d, eff_y;
   logic [PB-1:0] lb_rd [NM-1];

   feeder_state_t state_q, state_d;

   assign pix_ready = ~col_valid | col_ready;
   assign acc       = pix_valid & pix_ready;
   assign sof_acc   = acc & pix_sof;
   // A start-of-frame pixel is placed at (0,0) regardless of the running counters.
   assign eff_x     = sof_acc ? '0 : x_q;
   assign eff_y     = sof_acc ? '0 : y_q;
   assign last_pix  = (eff_x == XLast) && (eff_y == YLast);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (acc) begin
         if (eff_x == XLast) begin
            x_d = '0;
            y_d = (eff_y == YLast) ? '0 : eff_y + 1'b1;
         end else begin
            x_d = eff_x + 1'b1;
            y_d = eff_y;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (sof_acc) begin
         state_d = PRIME;
      end else if (acc) begin
         unique case (state_q)
            PRIME:   if (eff_x == XLast && eff_y == YPrimeLast) state_d = STREAM;
            STREAM:  if (last_pix) state_d = PRIME;
            default: state_d = PRIME;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q     <= '0;
         y_q     <= '0;
         state_q <= PRIME;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         state_q <= state_d;
      end
   end

   // Each memory shifts its old row down the chain; the newest takes the incoming pixel.
   for (genvar k = 0; k < NM - 1; k++) begin : g_lb
      logic [PB-1:0] wdata;
      if (k == NM - 2) begin : g_top
         assign wdata = pix_in;
      end else begin : g_mid
         assign wdata = lb_rd[k+1];
      end
      line_mem #(
         .Width(PB),
         .Depth(IMG_W),
         .AddrW(AW)
      ) u_lb (
         .clk  (clk),
         .we   (acc),
         .addr (eff_x[AW-1:0]),
         .wdata(wdata),
         .rdata(lb_rd[k])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NM; k++) col_data[k] <= '0;
         col_valid <= 1'b0;
         col_sol   <= 1'b0;
         col_eof   <= 1'b0;
         col_x     <= '0;
      end else if (acc) begin
         for (int k = 0; k < NM - 1; k++) col_data[k] <= lb_rd[k];
         col_data[NM-1] <= pix_in;
         col_x          <= eff_x;
         col_sol        <= (eff_x == '0);
         col_eof        <= last_pix;
         col_valid      <= (eff_y >= YFirstOut);
      end else if (col_ready) begin
         col_valid <= 1'b0;
      end
   end

endmodule
